sccpu_run_ctrl: RTL and testbench
=================================

# sccpu_run_ctrl

Run/halt/step controller for the single-cycle MIPS computer. It produces the CPU advance enable `cpu_en`, counts retired instructions, and compares the fetched PC against an optional breakpoint. While halted, it drives `reg_sel` to scan all 32 GPRs out through a valid/ready stream. It sits between the top-level computer and the host/bench command interface, which sends one command at a time.

## Interface
- `RUN_ON_RESET`, default 1: state after reset. 1 = RUN, 0 = HALT.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_op` in 3: 0 RUN, 1 HALT, 2 STEP, 3 DUMP, 4 SETBP, 5 CLRBP, 6–7 reserved (no-op).
- `cmd_arg` in 32: step count (STEP) or breakpoint address (SETBP).
- `pc` in 32: current CPU PC (registered inside CPU).
- `cpu_en` out 1: CPU updates PC/regfile/memory only when high.
- `reg_sel` out 5: register-file debug read select.
- `reg_data` in 32: combinational regfile read of `reg_sel`.
- `dump_valid` out 1, `dump_ready` in 1: dump stream handshake.
- `dump_data` out 32: equals `reg_data`.
- `dump_idx` out 5: equals `reg_sel`.
- `dump_last` out 1: high with index 31.
- `halted` out 1: state == HALT.
- `bp_hit` out 1: sticky; the last halt was caused by the breakpoint.
- `retired` out 32: count of cycles with `cpu_en` = 1.

## Operation
- States: HALT, RUN, STEP, DUMP.
- HALT: `cpu_en` = 0, `cmd_ready` = 1.
  - RUN → RUN.
  - STEP → STEP, with `step_cnt` = `cmd_arg`; `cmd_arg` = 0 is treated as 1.
  - DUMP → DUMP, with `reg_sel` = 0.
  - SETBP: `bp_addr` = `cmd_arg`, `bp_arm` = 1.
  - CLRBP: `bp_arm` = 0.
  - HALT: no-op.
- RUN: `cpu_en` = 1 unless a breakpoint matches; `cmd_ready` = 1.
  - HALT → HALT.
  - SETBP/CLRBP: act as in HALT.
  - RUN/STEP/DUMP/reserved: consumed, no effect.
- STEP: as RUN; `step_cnt` decrements each `cpu_en` cycle. When `step_cnt` == 1 and `cpu_en` = 1 → HALT next cycle, so exactly N instructions retire. A HALT command aborts the step.
- DUMP: `cpu_en` = 0, `cmd_ready` = 0, `dump_valid` = 1.
  - On handshake: `reg_sel` += 1.
  - On the handshake with `reg_sel` == 31: → HALT, with `reg_sel` returned to 0.
  - `dump_ready` low: `reg_sel` holds and `dump_data` tracks `reg_data`.
- Breakpoint match: `bp_arm && pc == bp_addr && !skip`, evaluated in RUN/STEP.
  - Match forces `cpu_en` = 0 that cycle, so the breakpointed instruction is not executed.
  - Next state HALT, `bp_hit` = 1.
- `skip`: set on any HALT→RUN or HALT→STEP transition, cleared after the first RUN/STEP cycle. Resuming from a breakpoint therefore executes the breakpointed instruction.
- `bp_hit` clears on the next accepted command of any op.
- `retired`: +1 on each `cpu_en` cycle, wraps 2^32−1 → 0.

## Timing
- Reset values:
  - State: RUN if `RUN_ON_RESET`, else HALT.
  - `cpu_en` = `RUN_ON_RESET`, `cmd_ready` = 1.
  - `reg_sel` = 0, `dump_valid` = 0, `dump_last` = 0.
  - `bp_hit` = 0, `bp_arm` = 0, `bp_addr` = 0, `retired` = 0.
  - `halted` = !`RUN_ON_RESET`.
- `rst` mid-DUMP or mid-STEP abandons the operation; outputs take reset values next edge.
- Command accepted at edge k → new state visible from cycle k+1:
  - `cpu_en` rises in cycle k+1 for RUN/STEP.
  - First `dump_valid` appears in cycle k+1.
- HALT accepted in RUN at edge k: `cpu_en` is still 1 in the cycle before edge k and 0 from cycle k+1.
- `cpu_en` is combinational from state, `bp` registers and `pc`. It has no combinational path from `cmd_*`.
- A 32-register dump takes 32 cycles minimum with `dump_ready` tied high.

## Configuration
- `SCCPU_RUN_CTRL_BP_EN` defined: breakpoint comparator, `bp_addr`/`bp_arm`/`skip` registers and `bp_hit` are present.
- Undefined:
  - SETBP/CLRBP are accepted as no-ops.
  - `bp_hit` is tied 0, no comparator is built, and RUN only leaves via HALT.

## Test plan
- Reset with `RUN_ON_RESET` = 0, then STEP `cmd_arg` = 3 → `cpu_en` high exactly 3 cycles, `retired` = 3, `halted` = 1; STEP with `cmd_arg` = 0 → 1 cycle, `retired` = 4.
- SETBP 0x0000_0010, RUN on the instruction stream → halt with `pc` = 0x10, `bp_hit` = 1, instruction at 0x10 not retired. RUN again → 0x10 executes and the breakpoint does not re-trigger immediately.
- DUMP from HALT with `dump_ready` toggling 1,0,1,… → 32 beats, `dump_idx` 0..31 in order, `dump_last` only on idx 31, `dump_data` matches the register contents (e.g., $7 value written by the program), `cmd_ready` = 0 throughout.
- During RUN send STEP/DUMP (ignored), then HALT → `cpu_en` drops the cycle after acceptance. Assert `rst` mid-DUMP at idx 12 → `reg_sel` = 0, `dump_valid` = 0 next cycle.
- Force `retired` = 0xFFFF_FFFF via a long run or preload, then step 1 → `retired` = 0. With `SCCPU_RUN_CTRL_BP_EN` undefined, SETBP then RUN → never halts, `bp_hit` stays 0.

Source files
------------

// File: rtl/sccpu_run_ctrl.sv
// Run/halt/step/dump controller for the single-cycle MIPS core; cpu_en is combinational from state, bp regs and pc.
// Optional breakpoint logic is built only when SCCPU_RUN_CTRL_BP_EN is defined.
module sccpu_run_ctrl #(
    parameter bit RUN_ON_RESET = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [2:0]  cmd_op_i,
    input  logic [31:0] cmd_arg_i,
    input  logic [31:0] pc_i,
    output logic        cpu_en_o,
    output logic [4:0]  reg_sel_o,
    input  logic [31:0] reg_data_i,
    output logic        dump_valid_o,
    input  logic        dump_ready_i,
    output logic [31:0] dump_data_o,
    output logic [4:0]  dump_idx_o,
    output logic        dump_last_o,
    output logic        halted_o,
    output logic        bp_hit_o,
    output logic [31:0] retired_o
);

    localparam logic [1:0] S_HALT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;
    localparam logic [1:0] S_DUMP = 2'd3;

    localparam logic [2:0] OP_RUN   = 3'd0;
    localparam logic [2:0] OP_HALT  = 3'd1;
    localparam logic [2:0] OP_STEP  = 3'd2;
    localparam logic [2:0] OP_DUMP  = 3'd3;
    localparam logic [2:0] OP_SETBP = 3'd4;
    localparam logic [2:0] OP_CLRBP = 3'd5;

    logic [1:0]  state_q, state_d;
    logic [31:0] step_cnt_q, step_cnt_d;
    logic [4:0]  reg_sel_q, reg_sel_d;
    logic [31:0] retired_q, retired_d;
    logic        accept;
    logic        active;
    logic        bp_match;
    logic        bp_hit_set;

    assign active      = (state_q == S_RUN) || (state_q == S_STEP);
    assign cmd_ready_o = (state_q != S_DUMP);
    assign accept      = cmd_valid_i && cmd_ready_o;

`ifdef SCCPU_RUN_CTRL_BP_EN
    logic [31:0] bp_addr_q, bp_addr_d;
    logic        bp_arm_q, bp_arm_d;
    logic        skip_q, skip_d;
    logic        bp_hit_q, bp_hit_d;

    // skip lets the instruction we stopped on execute once after resuming
    assign bp_match = active && bp_arm_q && (pc_i == bp_addr_q) && !skip_q;
    assign bp_hit_o = bp_hit_q;

    always_comb begin
        bp_addr_d = bp_addr_q;
        bp_arm_d  = bp_arm_q;
        skip_d    = skip_q;
        bp_hit_d  = bp_hit_q;
        if (accept) begin
            bp_hit_d = 1'b0;
            if (cmd_op_i == OP_SETBP) begin
                bp_addr_d = cmd_arg_i;
                bp_arm_d  = 1'b1;
            end else if (cmd_op_i == OP_CLRBP) begin
                bp_arm_d = 1'b0;
            end
        end
        if (active) begin
            skip_d = 1'b0;
        end else if (state_q == S_HALT && accept &&
                     (cmd_op_i == OP_RUN || cmd_op_i == OP_STEP)) begin
            skip_d = 1'b1;
        end
        if (bp_hit_set) begin
            bp_hit_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bp_addr_q <= 32'd0;
            bp_arm_q  <= 1'b0;
            skip_q    <= 1'b0;
            bp_hit_q  <= 1'b0;
        end else begin
            bp_addr_q <= bp_addr_d;
            bp_arm_q  <= bp_arm_d;
            skip_q    <= skip_d;
            bp_hit_q  <= bp_hit_d;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc_i;
    assign bp_match  = 1'b0;
    assign bp_hit_o  = 1'b0;
`endif

    assign cpu_en_o     = active && !bp_match;
    assign halted_o     = (state_q == S_HALT);
    assign dump_valid_o = (state_q == S_DUMP);
    assign dump_last_o  = (state_q == S_DUMP) && (reg_sel_q == 5'd31);
    assign reg_sel_o    = reg_sel_q;
    assign dump_idx_o   = reg_sel_q;
    assign dump_data_o  = reg_data_i;
    assign retired_o    = retired_q;
    assign retired_d    = retired_q + {31'd0, cpu_en_o};

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        reg_sel_d  = reg_sel_q;
        bp_hit_set = 1'b0;
        case (state_q)
            S_HALT: begin
                if (accept) begin
                    case (cmd_op_i)
                        OP_RUN:  state_d = S_RUN;
                        OP_STEP: begin
                            state_d    = S_STEP;
                            step_cnt_d = (cmd_arg_i == 32'd0) ? 32'd1 : cmd_arg_i;
                        end
                        OP_DUMP: begin
                            state_d   = S_DUMP;
                            reg_sel_d = 5'd0;
                        end
                        default: state_d = S_HALT;
                    endcase
                end
            end
            S_RUN, S_STEP: begin
                if (bp_match) begin
                    state_d    = S_HALT;
                    bp_hit_set = 1'b1;
                end else if (accept && cmd_op_i == OP_HALT) begin
                    state_d = S_HALT;
                end else if (state_q == S_STEP && cpu_en_o) begin
                    if (step_cnt_q == 32'd1) begin
                        state_d = S_HALT;
                    end else begin
                        step_cnt_d = step_cnt_q - 32'd1;
                    end
                end
            end
            default: begin
                if (dump_ready_i) begin
                    if (reg_sel_q == 5'd31) begin
                        state_d   = S_HALT;
                        reg_sel_d = 5'd0;
                    end else begin
                        reg_sel_d = reg_sel_q + 5'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN_ON_RESET ? S_RUN : S_HALT;
            step_cnt_q <= 32'd0;
            reg_sel_q  <= 5'd0;
            retired_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            reg_sel_q  <= reg_sel_d;
            retired_q  <= retired_d;
        end
    end

endmodule

// File: tb/tb_sccpu_run_ctrl.sv
// Directed bench for sccpu_run_ctrl with a toy CPU (pc += 4, $7 written each retire) and a dump scoreboard.
module tb_sccpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic [31:0] pc;
    logic        cpu_en;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [4:0]  dump_idx;
    logic        dump_last;
    logic        halted;
    logic        bp_hit;
    logic [31:0] retired;

    logic        d1_cmd_ready, d1_cpu_en, d1_dump_valid, d1_dump_last, d1_halted, d1_bp_hit;
    logic [4:0]  d1_reg_sel, d1_dump_idx;
    logic [31:0] d1_dump_data, d1_retired;

    logic [31:0] regs [32];

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] dat;
        logic        last;
    } beat_t;

    beat_t beat_q [$];
    beat_t exp_beat;
    int    n_cmp = 0;
    int    n_fail = 0;
    int    cnt;
    logic  tog;

    always #5 clk = ~clk;

    sccpu_run_ctrl #(.RUN_ON_RESET(1'b0)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_arg_i(cmd_arg),
        .pc_i(pc), .cpu_en_o(cpu_en),
        .reg_sel_o(reg_sel), .reg_data_i(reg_data),
        .dump_valid_o(dump_valid), .dump_ready_i(dump_ready),
        .dump_data_o(dump_data), .dump_idx_o(dump_idx), .dump_last_o(dump_last),
        .halted_o(halted), .bp_hit_o(bp_hit), .retired_o(retired)
    );

    sccpu_run_ctrl dut_run (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(1'b0), .cmd_ready_o(d1_cmd_ready),
        .cmd_op_i(3'd0), .cmd_arg_i(32'd0),
        .pc_i(32'd0), .cpu_en_o(d1_cpu_en),
        .reg_sel_o(d1_reg_sel), .reg_data_i(32'd0),
        .dump_valid_o(d1_dump_valid), .dump_ready_i(1'b0),
        .dump_data_o(d1_dump_data), .dump_idx_o(d1_dump_idx), .dump_last_o(d1_dump_last),
        .halted_o(d1_halted), .bp_hit_o(d1_bp_hit), .retired_o(d1_retired)
    );

    // Toy CPU: every retired instruction advances pc and writes $7
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= 32'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'h1000_0000 + 32'(i) * 32'h0101;
        end else if (cpu_en) begin
            pc      <= pc + 32'd4;
            regs[7] <= pc ^ 32'h5A5A_0000;
        end
    end
    assign reg_data = regs[reg_sel];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        check("cmd_ready_at_send", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic count_until_halt(output int n);
        n = 0;
        for (int i = 0; i < 40 && !halted; i++) begin
            if (cpu_en) n++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 32'd0; dump_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_halted",     32'(halted),     32'd1);
        check("rst_cpu_en",     32'(cpu_en),     32'd0);
        check("rst_cmd_ready",  32'(cmd_ready),  32'd1);
        check("rst_reg_sel",    32'(reg_sel),    32'd0);
        check("rst_dump_valid", 32'(dump_valid), 32'd0);
        check("rst_dump_last",  32'(dump_last),  32'd0);
        check("rst_bp_hit",     32'(bp_hit),     32'd0);
        check("rst_retired",    retired,         32'd0);
        check("rst1_cpu_en",    32'(d1_cpu_en),  32'd1);
        check("rst1_halted",    32'(d1_halted),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // STEP 3 then STEP 0 (treated as 1)
        send_cmd(3'd2, 32'd3);
        check("step3_first_en", 32'(cpu_en), 32'd1);
        count_until_halt(cnt);
        check("step3_cycles",  32'(cnt),    32'd3);
        check("step3_retired", retired,     32'd3);
        check("step3_halted",  32'(halted), 32'd1);
        send_cmd(3'd7, 32'd0);
        check("reserved_halted", 32'(halted), 32'd1);
        check("reserved_cpu_en", 32'(cpu_en), 32'd0);
        send_cmd(3'd2, 32'd0);
        count_until_halt(cnt);
        check("step0_cycles",  32'(cnt), 32'd1);
        check("step0_retired", retired,  32'd4);
        check("step0_pc",      pc,       32'h10);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifdef SCCPU_RUN_CTRL_BP_EN
        send_cmd(3'd4, 32'h10);
        send_cmd(3'd0, 32'd0);
        for (int i = 0; i < 50 && !halted; i++) @(negedge clk);
        check("bp_halted",  32'(halted), 32'd1);
        check("bp_pc",      pc,          32'h10);
        check("bp_hit",     32'(bp_hit), 32'd1);
        check("bp_retired", retired,     32'd4);
        check("bp_cpu_en",  32'(cpu_en), 32'd0);
        repeat (3) @(negedge clk);
        check("bp_hold_pc", pc, 32'h10);
        send_cmd(3'd0, 32'd0);
        check("resume_bp_hit", 32'(bp_hit), 32'd0);
        check("resume_cpu_en", 32'(cpu_en), 32'd1);
        @(negedge clk);
        check("resume_pc",      pc,          32'h14);
        check("resume_retired", retired,     32'd5);
        check("resume_running", 32'(halted), 32'd0);
`else
        send_cmd(3'd4, 32'h10);
        send_cmd(3'd0, 32'd0);
        repeat (30) @(negedge clk);
        check("nobp_halted",  32'(halted), 32'd0);
        check("nobp_bp_hit",  32'(bp_hit), 32'd0);
        check("nobp_retired", retired,     32'd30);
        check("nobp_cpu_en",  32'(cpu_en), 32'd1);
`endif

        // STEP/DUMP are ignored while running; HALT stops the next cycle
        send_cmd(3'd2, 32'd2);
        check("run_step_ign_halted", 32'(halted), 32'd0);
        check("run_step_ign_en",     32'(cpu_en), 32'd1);
        send_cmd(3'd3, 32'd0);
        check("run_dump_ign_valid",  32'(dump_valid), 32'd0);
        check("run_dump_ign_en",     32'(cpu_en),     32'd1);
        repeat (3) @(negedge clk);
        check("pre_halt_en", 32'(cpu_en), 32'd1);
        send_cmd(3'd1, 32'd0);
        check("halt_en",     32'(cpu_en), 32'd0);
        check("halt_halted", 32'(halted), 32'd1);

        // DUMP with dump_ready toggling
        beat_q.delete();
        for (int i = 0; i < 32; i++) beat_q.push_back('{idx: 5'(i), dat: regs[i], last: (i == 31)});
        check("dump_r7_written", 32'(regs[7][31:16] == 16'h5A5A), 32'd1);
        dump_ready = 1'b1;
        send_cmd(3'd3, 32'd0);
        check("dump_first_valid", 32'(dump_valid), 32'd1);
        tog = 1'b1;
        for (int c = 0; c < 200 && beat_q.size() > 0; c++) begin
            dump_ready = tog;
            #1;
            check("dump_cmd_ready", 32'(cmd_ready),  32'd0);
            check("dump_valid",     32'(dump_valid), 32'd1);
            if (dump_ready) begin
                exp_beat = beat_q.pop_front();
                check("dump_idx",  32'(dump_idx),  32'(exp_beat.idx));
                check("dump_data", dump_data,      exp_beat.dat);
                check("dump_last", 32'(dump_last), 32'(exp_beat.last));
            end
            @(negedge clk);
            tog = !tog;
        end
        dump_ready = 1'b0;
        check("dump_beats_left", 32'(beat_q.size()), 32'd0);
        check("dump_end_halted", 32'(halted),     32'd1);
        check("dump_end_valid",  32'(dump_valid), 32'd0);
        check("dump_end_sel",    32'(reg_sel),    32'd0);

        // Reset in the middle of a dump
        dump_ready = 1'b1;
        send_cmd(3'd3, 32'd0);
        for (int i = 0; i < 40 && dump_idx != 5'd12; i++) @(negedge clk);
        check("mid_dump_idx", 32'(dump_idx), 32'd12);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_sel",     32'(reg_sel),    32'd0);
        check("mid_rst_valid",   32'(dump_valid), 32'd0);
        check("mid_rst_halted",  32'(halted),     32'd1);
        check("mid_rst_ready",   32'(cmd_ready),  32'd1);
        check("mid_rst_retired", retired,         32'd0);
        rst = 1'b0;
        dump_ready = 1'b0;
        @(negedge clk);

        // Retired counter wraps
        force dut.retired_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retired_q;
        check("wrap_preload", retired, 32'hFFFF_FFFF);
        send_cmd(3'd2, 32'd1);
        count_until_halt(cnt);
        check("wrap_cycles",  32'(cnt), 32'd1);
        check("wrap_retired", retired,  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
